// File: rtl/i2s_mic_receiver_if.sv
// I2S microphone bus between the receiver (I2S master) and the microphone.
//   sck     : bit clock, driven by the receiver
//   ws      : word select, driven by the receiver
//   sd      : serial data from the microphone (asynchronous to clk)
//   mic     : last captured 24-bit two's-complement sample, held
//   mic_vld : one-cycle strobe when mic takes a new value
// modport master is the receiver side; modport slave is the microphone /
// downstream side.
interface i2s_mic_receiver_if;
    logic        sck;
    logic        ws;
    logic        sd;
    logic [23:0] mic;
    logic        mic_vld;

    modport master (output sck, ws, mic, mic_vld, input sd);
    modport slave  (input sck, ws, mic, mic_vld, output sd);
endinterface

// File: rtl/i2s_mic_receiver.sv
// I2S master receiver for a 24-bit MEMS microphone.
// Generates SCK/WS from clk, deserialises the selected slot MSB-first and
// presents a held signed sample on mic with a one-cycle mic_vld strobe per
// 64-SCK frame.
// Ports:
//   clk : system clock, all logic on its rising edge
//   rst : synchronous active-high reset
//   bus : i2s_mic_receiver_if.master (sck, ws, mic, mic_vld out; sd in)
// Parameters:
//   clk_mhz  : system clock frequency, only used for a sanity assertion
//   sck_half : clk cycles per SCK half period (>= 4)
//   channel  : 0 = left slot (WS low), 1 = right slot (WS high)
module i2s_mic_receiver #(
    parameter int clk_mhz  = 50,
    parameter int sck_half = 8,
    parameter bit channel  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    i2s_mic_receiver_if.master bus
);
    localparam int              d_w       = $clog2(sck_half);
    localparam logic [d_w-1:0]  d_last    = d_w'(sck_half - 1);
    // One-bit delay after the WS edge: data occupies b = 1..24 of the slot.
    localparam logic [5:0]      first_bit = channel ? 6'd33 : 6'd1;
    localparam logic [5:0]      last_bit  = channel ? 6'd56 : 6'd24;

    logic [d_w-1:0] d_reg, d_next;
    logic           sck_reg, sck_next;
    logic           ws_reg, ws_next;
    logic [5:0]     b_reg, b_next;
    logic [1:0]     sync_reg;
    logic [23:0]    shift_reg, shift_next;
    logic           done_reg, done_next;
    logic [23:0]    mic_reg, mic_next;
    logic           vld_reg;

    logic tick;
    logic rise;
    logic fall;
    logic in_window;

    always_comb begin
        tick       = (d_reg == d_last);
        rise       = tick && !sck_reg;
        fall       = tick && sck_reg;
        d_next     = tick ? '0 : d_reg + d_w'(1);
        sck_next   = tick ? !sck_reg : sck_reg;
        b_next     = fall ? b_reg + 6'd1 : b_reg;
        // WS follows the new frame position so it changes with SCK falling.
        ws_next    = fall ? b_next[5] : ws_reg;
        in_window  = (b_reg >= first_bit) && (b_reg <= last_bit);
        shift_next = (rise && in_window) ? {shift_reg[22:0], sync_reg[1]} : shift_reg;
        // Flag the capture of the last window bit; the sample is published
        // on the following clk edge so the shift register already holds it.
        done_next  = rise && (b_reg == last_bit);
        mic_next   = done_reg ? shift_reg : mic_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_reg     <= '0;
            sck_reg   <= 1'b0;
            ws_reg    <= 1'b0;
            b_reg     <= '0;
            sync_reg  <= '0;
            shift_reg <= '0;
            done_reg  <= 1'b0;
            mic_reg   <= '0;
            vld_reg   <= 1'b0;
        end else begin
            assert (sck_half >= 4 && clk_mhz > 0);
            d_reg     <= d_next;
            sck_reg   <= sck_next;
            ws_reg    <= ws_next;
            b_reg     <= b_next;
            // sd is asynchronous; only the second flop feeds the capture.
            sync_reg  <= {sync_reg[0], bus.sd};
            shift_reg <= shift_next;
            done_reg  <= done_next;
            mic_reg   <= mic_next;
            vld_reg   <= done_reg;
        end
    end

    assign bus.sck     = sck_reg;
    assign bus.ws      = ws_reg;
    assign bus.mic     = mic_reg;
    assign bus.mic_vld = vld_reg;
endmodule

// File: tb/tb_i2s_mic_receiver.sv
// Self-checking bench for i2s_mic_receiver.
// Three receivers share clk/rst: left slot at sck_half 8, right slot at
// sck_half 8, and left slot at the minimum sck_half 4. Each has its own
// microphone model that follows WS/SCK like a real I2S mic, launching data
// on SCK falls one bit after each WS edge and driving noise elsewhere.
// Expected sck/ws/mic/mic_vld are computed arithmetically from the edge
// number after reset release.
module tb_i2s_mic_receiver;
    localparam int SH [3] = '{8, 8, 4};
    localparam bit CH [3] = '{1'b0, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  sck_w;
    logic [2:0]  ws_w;
    logic [2:0]  vld_w;
    logic [23:0] mic_w [3];
    logic [23:0] words [3][128];
    logic [23:0] exp_mic [3];
    int          k = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        i2s_mic_receiver_if bus ();

        i2s_mic_receiver #(
            .clk_mhz (50),
            .sck_half(SH[gi]),
            .channel (CH[gi])
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );

        assign sck_w[gi] = bus.sck;
        assign ws_w[gi]  = bus.ws;
        assign vld_w[gi] = bus.mic_vld;
        assign mic_w[gi] = bus.mic;

        // Microphone model: slot position counts SCK falls since the last
        // WS change; positions 1..24 carry the word MSB-first.
        logic        sd_drv   = 1'b0;
        logic        prev_sck = 1'b0;
        logic        prev_ws  = 1'b0;
        int          pos      = 0;
        int          starts   = 0;
        logic [23:0] cur      = '0;
        logic [23:0] other    = '0;
        assign bus.sd = sd_drv;

        always @(negedge clk) begin
            if (rst) begin
                pos      = 0;
                prev_sck = 1'b0;
                prev_ws  = 1'b0;
                sd_drv   = 1'b1;
                // A left-slot receiver's first slot begins at reset itself.
                starts   = CH[gi] ? 0 : 1;
                cur      = words[gi][0];
                other    = 24'($urandom);
            end else begin
                if (prev_sck && !bus.sck) begin
                    if (bus.ws != prev_ws) begin
                        pos = 0;
                        if (bus.ws == CH[gi]) begin
                            cur    = words[gi][starts % 128];
                            starts = starts + 1;
                        end else begin
                            other = 24'($urandom);
                        end
                    end else begin
                        pos = pos + 1;
                    end
                    if (pos >= 1 && pos <= 24)
                        sd_drv = (bus.ws == CH[gi]) ? cur[24 - pos] : other[24 - pos];
                    else
                        sd_drv = (gi == 0) ? 1'b1 : 1'($urandom);
                end
                prev_sck = bus.sck;
                prev_ws  = bus.ws;
            end
        end
    end

    task automatic chk(input string tag, input int inst,
                       input logic [23:0] obs, input logic [23:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d] k=%0d: got %h, want %h", tag, inst, k, obs, exp);
        end
    endtask

    task automatic fill_words();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 128; j++)
                words[i][j] = 24'($urandom);
    endtask

    // Hold reset for n edges, checking all outputs are cleared.
    task automatic reset_cycles(input int n);
        rst = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                chk("rst_sck", i, 24'(sck_w[i]), 24'd0);
                chk("rst_ws",  i, 24'(ws_w[i]),  24'd0);
                chk("rst_vld", i, 24'(vld_w[i]), 24'd0);
                chk("rst_mic", i, mic_w[i],      24'd0);
            end
        end
        rst = 1'b0;
        k   = 0;
        for (int i = 0; i < 3; i++) exp_mic[i] = '0;
    endtask

    // Advance one clk edge and compare every receiver to the timing rules.
    task automatic step_check();
        int   sh;
        int   first;
        int   per;
        logic e_sck;
        logic e_ws;
        logic e_vld;
        @(posedge clk);
        #1;
        k++;
        for (int i = 0; i < 3; i++) begin
            sh    = SH[i];
            first = 2 * sh * (CH[i] ? 56 : 24) + sh + 1;
            per   = 128 * sh;
            e_sck = ((k / sh) % 2) == 1;
            e_ws  = ((k / (2 * sh)) % 64) >= 32;
            e_vld = (k >= first) && (((k - first) % per) == 0);
            if (e_vld) exp_mic[i] = words[i][(k - first) / per];
            chk("sck", i, 24'(sck_w[i]), 24'(e_sck));
            chk("ws",  i, 24'(ws_w[i]),  24'(e_ws));
            chk("vld", i, 24'(vld_w[i]), 24'(e_vld));
            chk("mic", i, mic_w[i],      exp_mic[i]);
        end
    endtask

    initial begin
        // Phase A: left 0x800001 (noise 1s), right 0xA5A5A5, random at sck_half 4.
        fill_words();
        words[0][0] = 24'h800001;
        words[1][0] = 24'hA5A5A5;
        reset_cycles(5);
        repeat (1224) step_check();

        // Reset at edge 200 of the second frame, then stream directed and
        // random words; the sck_half 4 receiver runs for over 100 frames.
        fill_words();
        words[0][0] = 24'h000000;
        words[0][1] = 24'h7FFFFF;
        words[0][2] = 24'h123456;
        words[1][0] = 24'hA5A5A5;
        reset_cycles(1);
        repeat (51300) step_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/i2s_mic_receiver.md
# i2s_mic_receiver

I2S master receiver for a 24-bit MEMS microphone (INMP441-class), sitting directly upstream of the note recognizer. Generates the microphone's bit clock and word select from the system clock, deserialises the selected channel MSB-first, and presents a held, signed 24-bit `mic` sample with a one-cycle `mic_vld` strobe once per frame. The downstream stage reads `mic` continuously, so the value is held between updates.

## Interface

- `clk_mhz`, 50: system clock frequency; informational, used only for sanity assertions.
- `sck_half`, 8: `clk` cycles per SCK half-period; legal range ≥ 4. The default gives 3.125 MHz SCK and about 48.8 kHz sample rate at 50 MHz.
- `channel`, 0: 0 captures the left slot (WS low); 1 captures the right slot (WS high).

- `clk`  in  1: system clock; all logic is on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `sck`  out  1: I2S bit clock to the microphone; registered output.
- `ws`  out  1: I2S word select; registered output, changes only on SCK falling edges.
- `sd`  in  1: serial data from the microphone; asynchronous to `clk`.
- `mic`  out  24: last captured sample, two's complement, held between updates.
- `mic_vld`  out  1: one-cycle pulse, high in the cycle `mic` takes a new value.

## Operation

- **Divider**
  - `d` counts 0..`sck_half`-1 and wraps.
  - On an edge where `d == sck_half-1`, `sck` toggles.
  - A rise edge is a toggle with `sck` = 0; a fall edge is a toggle with `sck` = 1.
- **Frame counter**
  - 6-bit `b` counts 0..63 and increments on every fall edge, wrapping 63→0.
  - `ws` <= new `b[5]` on the same edge.
  - Each frame is 64 SCK periods: `ws` = 0 for b = 0..31 and 1 for b = 32..63.
- **Input sync**: `sd` passes through a 2-flop synchroniser; only the second flop is used.
- **Capture**
  - On each rise edge with b in the data window, the synchronised `sd` shifts into a 24-bit register, LSB-in, MSB arriving first.
  - The data window is b = 1..24 when `channel` = 0 and b = 33..56 when `channel` = 1. This is the standard I2S one-bit delay after the WS edge.
  - Bits outside the window are ignored; the microphone tri-states there, so the level is arbitrary.
- **Output**
  - On the clock edge after the rise edge that captures the last window bit (b = 24 or 56), `mic` <= the shift register and `mic_vld` = 1 for exactly one cycle.
  - `mic` is never modified at any other time.
  - No sign extension or scaling is applied.
- **Reset values**
  - Outputs: `sck` = 0, `ws` = 0, `mic` = 0, `mic_vld` = 0.
  - Internal: `d` = 0, `b` = 0, shift register = 0, sync flops = 0.
- **Reset mid-frame**
  - The partial sample is discarded and `mic` returns to 0.
  - The frame restarts at b = 0 with no `mic_vld` until a full window has been captured after reset release.

## Timing

- Edge numbering: edge k is the k-th rising `clk` edge after `rst` deasserts, with k = 1 as the first edge after the reset edge.
- `sck` rises at edge `sck_half`·(2n+1) and falls at edge `sck_half`·(2n+2). SCK period = 2·`sck_half` clk.
- Frame length = 128·`sck_half` clk (1024 at default); `mic_vld` rate is exactly one per frame.
- Capture of bit b happens at edge 2·`sck_half`·b + `sck_half`.
- First `mic_vld` edges, with defaults:
  - `channel` = 0: 2·8·24 + 8 + 1 = 393.
  - `channel` = 1: 16·56 + 9 = 905.
  - Each subsequent strobe follows exactly 1024 edges later.
- `sd` validity: `sd` must be stable for at least 3 clk before the capture edge. The microphone launches on the preceding SCK fall, `sck_half` ≥ 4 clk earlier, and the synchroniser consumes 2 clk.
- Output latency: the last serial bit appears on `mic` 1 clk after its capture edge, plus 2 clk of synchroniser delay relative to the `sd` pin.

## Test plan

- **Reset values and clocks**: hold `rst` for 5 cycles → all outputs 0. After release, `sck` has a 16-clk period and 50 % duty, `ws` has a 1024-clk period, and `ws` edges coincide with `sck` falls.
- **Left capture**: microphone model on `ws`/`sck` drives 0x800001 in slot b = 1..24 and 0xFFFFFF noise elsewhere → `mic` = 0x800001 and `mic_vld` = 1 at edge 393 only. The right slot does not change `mic`.
- **Stream**: samples 0x000000, 0x7FFFFF, 0x123456 in consecutive frames → `mic_vld` at edges 393, 1417, 2441 with matching `mic`; `mic` is held constant between strobes.
- **Right channel**: `channel` = 1 with 0xA5A5A5 in the right slot → `mic` = 0xA5A5A5 at edge 905.
- **Reset mid-frame**: assert `rst` at edge 200 of a frame → `mic` = 0 next cycle and no strobe from the aborted frame. The first strobe after release falls at release-relative edge 393.
- **Minimum divider**: `sck_half` = 4 with random 24-bit data over 100 frames → every `mic` equals the driven word and strobes are exactly 512 clk apart.
